id_ex_stage: RTL

- Decode-to-execute pipeline boundary; sits directly upstream of the 16-bit execute ALU and drives its InA, InB, Oper, invA, invB, Cin and sign inputs.
- Latches decoded operands and control each cycle and supports stall, flush, bubble insertion and load-use hazard detection.
- Forwards results from the EX/MEM and MEM/WB stages onto the ALU operand paths.

---
 rtl/id_ex_if.sv | 48 ++++
 rtl/id_ex_stage.sv | 73 +++++++
 2 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX boundary bundle (decode fields, forward buses, EX outputs)
// master: pipeline control side driving decode fields, stall/flush and forward buses
// slave : id_ex_stage, returning latched EX fields and the load-use stall request
interface id_ex_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_BITS   = 3,
    parameter int OPER_WIDTH = 4
);
    logic                  stall, flush;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
    logic [REG_BITS-1:0]   id_rs, id_rt, id_rd;
    logic                  id_uses_rs, id_uses_rt, id_alu_src;
    logic [OPER_WIDTH-1:0] id_oper;
    logic                  id_invA, id_invB, id_cin, id_sign;
    logic                  id_reg_write, id_mem_read, id_mem_write;
    logic                  exm_reg_write;
    logic [REG_BITS-1:0]   exm_rd;
    logic [DATA_WIDTH-1:0] exm_result;
    logic                  mwb_reg_write;
    logic [REG_BITS-1:0]   mwb_rd;
    logic [DATA_WIDTH-1:0] mwb_result;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_InA, ex_InB, ex_store_data;
    logic [OPER_WIDTH-1:0] ex_oper;
    logic                  ex_invA, ex_invB, ex_cin, ex_sign;
    logic [REG_BITS-1:0]   ex_rd;
    logic                  ex_reg_write, ex_mem_read, ex_mem_write;
    logic                  load_use_stall;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_uses_rs, id_uses_rt, id_alu_src, id_oper, id_invA, id_invB, id_cin, id_sign,
               id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        input  ex_valid, ex_InA, ex_InB, ex_store_data, ex_oper, ex_invA, ex_invB, ex_cin,
               ex_sign, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_uses_rs, id_uses_rt, id_alu_src, id_oper, id_invA, id_invB, id_cin, id_sign,
               id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        output ex_valid, ex_InA, ex_InB, ex_store_data, ex_oper, ex_invA, ex_invB, ex_cin,
               ex_sign, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, stall/flush and load-use bubbles
// clk, rst : clock and asynchronous active-high reset
// bus      : id_ex_if slave; decode fields and forward buses in, ALU operands/controls out
module id_ex_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_BITS   = 3,
    parameter int OPER_WIDTH = 4
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic                  v, alu_src, reg_write, mem_read, mem_write;
    logic [DATA_WIDTH-1:0] rs_data, rt_data, imm, fwd_rs, fwd_rt;
    logic [REG_BITS-1:0]   rs, rt, rd;
    logic [OPER_WIDTH-1:0] oper;
    logic                  inv_a, inv_b, cin, sgn, lu;

    // the load in EX leaves on the next edge, so this yields exactly one bubble
    assign lu = v & mem_read & bus.id_valid &
                ((bus.id_uses_rs & (bus.id_rs == rd)) | (bus.id_uses_rt & (bus.id_rt == rd)));

    // EX/MEM is the younger result, so it beats MEM/WB when both match
    always_comb begin
        fwd_rs = (bus.exm_reg_write && bus.exm_rd == rs) ? bus.exm_result :
                 (bus.mwb_reg_write && bus.mwb_rd == rs) ? bus.mwb_result : rs_data;
        fwd_rt = (bus.exm_reg_write && bus.exm_rd == rt) ? bus.exm_result :
                 (bus.mwb_reg_write && bus.mwb_rd == rt) ? bus.mwb_result : rt_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {v, alu_src, reg_write, mem_read, mem_write} <= '0;
            {rs_data, rt_data, imm} <= '0;
            {rs, rt, rd} <= '0;
            {oper, inv_a, inv_b, cin, sgn} <= '0;
        end else if (bus.flush) begin
            v <= 1'b0;
        end else if (!bus.stall) begin
            v         <= bus.id_valid & ~lu;
            alu_src   <= bus.id_alu_src;
            reg_write <= bus.id_reg_write;
            mem_read  <= bus.id_mem_read;
            mem_write <= bus.id_mem_write;
            rs_data   <= bus.id_rs_data;
            rt_data   <= bus.id_rt_data;
            imm       <= bus.id_imm;
            rs        <= bus.id_rs;
            rt        <= bus.id_rt;
            rd        <= bus.id_rd;
            oper      <= bus.id_oper;
            inv_a     <= bus.id_invA;
            inv_b     <= bus.id_invB;
            cin       <= bus.id_cin;
            sgn       <= bus.id_sign;
        end
    end

    assign bus.ex_valid       = v;
    assign bus.ex_InA         = fwd_rs;
    assign bus.ex_InB         = alu_src ? imm : fwd_rt;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_oper        = oper;
    assign bus.ex_invA        = inv_a;
    assign bus.ex_invB        = inv_b;
    assign bus.ex_cin         = cin;
    assign bus.ex_sign        = sgn;
    assign bus.ex_rd          = rd;
    assign bus.ex_reg_write   = reg_write & v;
    assign bus.ex_mem_read    = mem_read & v;
    assign bus.ex_mem_write   = mem_write & v;
    assign bus.load_use_stall = lu;
endmodule
